aurora_tx_frame_scheduler: RTL and testbench

//  Sequences 64b/66b frames into the TX scrambler for the Aurora output lane.
//  - Arbitrates one frame slot per clk between service (register-readback) frames, hit data frames and idle fill.
//  - Runs the post-reset link-init sequence.
//  - Drives scrambler enable, sync header and payload.
//  - Honours gearbox back-pressure (pause).

---
 rtl/aurora_tx_pkg.sv | 21 ++
 rtl/aurora_slot_timer.sv | 42 ++++
 rtl/aurora_tx_frame_scheduler.sv | 137 +++++++++++++
 tb/tb_aurora_tx_frame_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared constants and types for the Aurora TX frame scheduler.
package aurora_tx_pkg;

  localparam logic [1:0]  SYNC_DATA  = 2'b01;
  localparam logic [1:0]  SYNC_CTRL  = 2'b10;
  localparam logic [7:0]  BT_IDLE    = 8'h78;
  localparam logic [7:0]  BT_SERVICE = 8'hD2;
  localparam logic [63:0] IDLE_WORD  = {BT_IDLE, 56'h10_0000_0000_0000};
  localparam logic [63:0] CB_WORD    = {BT_IDLE, 56'h40_0000_0000_0000};

  typedef enum logic [1:0] {
    FT_IDLE    = 2'd0,
    FT_CB      = 2'd1,
    FT_DATA    = 2'd2,
    FT_SERVICE = 2'd3
  } frame_type_e;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/aurora_slot_timer.sv
// Pause-gated 0..PERIOD-1 wrap counter with a sticky due flag set at wrap, cleared by clr.
// State advances only when en is high; the due flag is registered (visible the slot after the wrap).
module aurora_slot_timer #(
  parameter int PERIOD = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic due
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             due_q, due_d;
  logic             wrap;

  assign wrap = en & (cnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    // A wrap coinciding with a clear re-arms the flag; extra wraps never stack.
    due_d = wrap | (due_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      due_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      due_q <= due_d;
    end
  end

  assign due = due_q;

endmodule

// File: rtl/aurora_tx_frame_scheduler.sv
// Aurora TX frame scheduler: link-init CB/IDLE run, then service/data/idle arbitration; scr_* one cycle after the slot.
// gb_pause removes the slot (ready=0, state frozen, scr_* held); TX_CB_PERIODIC_EN adds periodic CB insertion.
module aurora_tx_frame_scheduler
  import aurora_tx_pkg::*;
#(
  parameter int TX_DATA_WIDTH  = 64,
  parameter int INIT_FRAMES    = 64,
  parameter int SERVICE_PERIOD = 50,
  parameter int CB_PERIOD      = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     gb_pause,
  input  logic                     data_valid,
  input  logic [TX_DATA_WIDTH-1:0] data_in,
  output logic                     data_ready,
  input  logic                     svc_valid,
  input  logic [TX_DATA_WIDTH-9:0] svc_in,
  output logic                     svc_ready,
  output logic                     scr_enable,
  output logic [1:0]               scr_sync,
  output logic [TX_DATA_WIDTH-1:0] scr_data,
  output logic [1:0]               frame_type,
  output logic                     init_done
);

  logic [0:0]               state_q, state_d;
  logic [15:0]              init_cnt_q, init_cnt_d;
  logic                     scr_enable_q, scr_enable_d;
  logic [1:0]               scr_sync_q, scr_sync_d;
  logic [TX_DATA_WIDTH-1:0] scr_data_q, scr_data_d;
  logic [1:0]               frame_type_q, frame_type_d;
  logic                     slot, run_slot;
  logic                     svc_due, svc_clr, cb_due;
  logic                     svc_sel, data_sel;

  assign slot     = reset_n & ~gb_pause;
  assign run_slot = slot & (state_q == ST_RUN);

  aurora_slot_timer #(.PERIOD(SERVICE_PERIOD)) u_svc_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_slot),
    .clr     (svc_clr),
    .due     (svc_due)
  );

`ifdef TX_CB_PERIODIC_EN
  logic cb_clr;
  assign cb_clr = run_slot & cb_due;

  aurora_slot_timer #(.PERIOD(CB_PERIOD)) u_cb_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_slot),
    .clr     (cb_clr),
    .due     (cb_due)
  );
`else
  logic cb_period_unused;
  assign cb_period_unused = ^CB_PERIOD;
  assign cb_due = 1'b0;
`endif

  // An idle slot may carry service early without consuming the due flag.
  assign svc_sel    = ~cb_due & svc_valid & (svc_due | ~data_valid);
  assign data_sel   = ~cb_due & data_valid & ~(svc_due & svc_valid);
  assign data_ready = run_slot & data_sel;
  assign svc_ready  = run_slot & svc_sel;
  assign svc_clr    = svc_ready & svc_due;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    scr_enable_d = slot;
    scr_sync_d   = scr_sync_q;
    scr_data_d   = scr_data_q;
    frame_type_d = frame_type_q;
    if (slot) begin
      if (state_q == ST_INIT) begin
        init_cnt_d = init_cnt_q + 16'd1;
        scr_sync_d = SYNC_CTRL;
        if (init_cnt_q[0]) begin
          scr_data_d   = IDLE_WORD;
          frame_type_d = FT_IDLE;
        end else begin
          scr_data_d   = CB_WORD;
          frame_type_d = FT_CB;
        end
        if (init_cnt_q == 16'(INIT_FRAMES - 1)) begin
          state_d = ST_RUN;
        end
      end else if (cb_due) begin
        scr_sync_d   = SYNC_CTRL;
        scr_data_d   = CB_WORD;
        frame_type_d = FT_CB;
      end else if (svc_sel) begin
        scr_sync_d   = SYNC_CTRL;
        scr_data_d   = {BT_SERVICE, svc_in};
        frame_type_d = FT_SERVICE;
      end else if (data_sel) begin
        scr_sync_d   = SYNC_DATA;
        scr_data_d   = data_in;
        frame_type_d = FT_DATA;
      end else begin
        scr_sync_d   = SYNC_CTRL;
        scr_data_d   = IDLE_WORD;
        frame_type_d = FT_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      scr_enable_q <= 1'b0;
      scr_sync_q   <= SYNC_CTRL;
      scr_data_q   <= IDLE_WORD;
      frame_type_q <= FT_IDLE;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      scr_enable_q <= scr_enable_d;
      scr_sync_q   <= scr_sync_d;
      scr_data_q   <= scr_data_d;
      frame_type_q <= frame_type_d;
    end
  end

  assign scr_enable = scr_enable_q;
  assign scr_sync   = scr_sync_q;
  assign scr_data   = scr_data_q;
  assign frame_type = frame_type_q;
  assign init_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_aurora_tx_frame_scheduler.sv
// Bench for aurora_tx_frame_scheduler: reference model fills a frame scoreboard, scenario tasks add targeted checks.
module tb_aurora_tx_frame_scheduler;
  import aurora_tx_pkg::*;

`ifdef TX_CB_PERIODIC_EN
  localparam int SP  = 8;
  localparam int CBP = 8;
`else
  localparam int SP  = 50;
  localparam int CBP = 256;
`endif
  localparam int INITF = 4;

  logic        clk = 1'b0;
  logic        reset_n, gb_pause, data_valid, svc_valid;
  logic [63:0] data_in;
  logic [55:0] svc_in;
  logic        data_ready, svc_ready, scr_enable, init_done;
  logic [1:0]  scr_sync, frame_type;
  logic [63:0] scr_data;

  always #5 clk = ~clk;

  aurora_tx_frame_scheduler #(
    .TX_DATA_WIDTH (64),
    .INIT_FRAMES   (INITF),
    .SERVICE_PERIOD(SP),
    .CB_PERIOD     (CBP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gb_pause   (gb_pause),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .svc_valid  (svc_valid),
    .svc_in     (svc_in),
    .svc_ready  (svc_ready),
    .scr_enable (scr_enable),
    .scr_sync   (scr_sync),
    .scr_data   (scr_data),
    .frame_type (frame_type),
    .init_done  (init_done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  sync;
    logic [63:0] dat;
    logic [1:0]  ft;
    logic        done;
  } exp_t;

  exp_t        q[$];
  frame_type_e ft_log[$];
  logic [63:0] data_log[$];

  logic m_run = 1'b0;
  int   m_init = 0, m_svc_cnt = 0, m_cb_cnt = 0;
  logic m_svc_due = 1'b0, m_cb_due = 1'b0;

  function automatic logic exp_svc_rdy();
    return reset_n && !gb_pause && m_run && !m_cb_due && svc_valid && (m_svc_due || !data_valid);
  endfunction

  function automatic logic exp_data_rdy();
    return reset_n && !gb_pause && m_run && !m_cb_due && data_valid && !(m_svc_due && svc_valid);
  endfunction

  // Reference model: decide each slot's frame from the inputs at the clock edge.
  always @(posedge clk) begin
    exp_t e;
    logic sclr, cclr;
    sclr = 1'b0;
    cclr = 1'b0;
    e    = '0;
    if (!reset_n) begin
      m_run = 0; m_init = 0; m_svc_cnt = 0; m_cb_cnt = 0; m_svc_due = 0; m_cb_due = 0;
      q.delete();
    end else if (!gb_pause) begin
      e.sync = SYNC_CTRL;
      if (!m_run) begin
        if (m_init % 2 == 0) begin e.dat = CB_WORD;   e.ft = FT_CB;   end
        else                 begin e.dat = IDLE_WORD; e.ft = FT_IDLE; end
        if (m_init == INITF - 1) m_run = 1'b1;
        m_init++;
        e.done = m_run;
      end else begin
        e.done = 1'b1;
        if (m_cb_due) begin
          e.dat = CB_WORD; e.ft = FT_CB; cclr = 1'b1;
        end else if (m_svc_due && svc_valid) begin
          e.dat = {BT_SERVICE, svc_in}; e.ft = FT_SERVICE; sclr = 1'b1;
        end else if (data_valid) begin
          e.sync = SYNC_DATA; e.dat = data_in; e.ft = FT_DATA;
        end else if (svc_valid) begin
          e.dat = {BT_SERVICE, svc_in}; e.ft = FT_SERVICE;
        end else begin
          e.dat = IDLE_WORD; e.ft = FT_IDLE;
        end
        if (m_svc_cnt == SP - 1) begin m_svc_cnt = 0; m_svc_due = 1'b1; end
        else begin m_svc_cnt++; if (sclr) m_svc_due = 1'b0; end
`ifdef TX_CB_PERIODIC_EN
        if (m_cb_cnt == CBP - 1) begin m_cb_cnt = 0; m_cb_due = 1'b1; end
        else begin m_cb_cnt++; if (cclr) m_cb_due = 1'b0; end
`endif
      end
      q.push_back(e);
    end
  end

  // Scoreboard: every emitted frame is popped and compared; silent cycles must hold scr_*.
  logic [63:0] prev_data;
  logic [1:0]  prev_sync;
  always @(posedge clk) begin
    exp_t e;
    #1;
    total++;
    if (!reset_n) begin
      if (scr_enable !== 1'b0 || scr_sync !== SYNC_CTRL || scr_data !== IDLE_WORD ||
          frame_type !== 2'd0 || init_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: en=%b sync=%b data=%h ft=%0d done=%b", scr_enable, scr_sync, scr_data, frame_type, init_done);
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      if (scr_enable !== 1'b1 || scr_sync !== e.sync || scr_data !== e.dat ||
          frame_type !== e.ft || init_done !== e.done) begin
        bad++;
        $display("FAIL frame: got en=%b sync=%b data=%h ft=%0d done=%b, want en=1 sync=%b data=%h ft=%0d done=%b",
                 scr_enable, scr_sync, scr_data, frame_type, init_done, e.sync, e.dat, e.ft, e.done);
      end
      ft_log.push_back(frame_type_e'(frame_type));
      if (frame_type == FT_DATA) data_log.push_back(scr_data);
    end else begin
      if (scr_enable !== 1'b0 || scr_data !== prev_data || scr_sync !== prev_sync) begin
        bad++;
        $display("FAIL hold: en=%b data=%h sync=%b, want en=0 data=%h sync=%b", scr_enable, scr_data, scr_sync, prev_data, prev_sync);
      end
    end
    prev_data = scr_data;
    prev_sync = scr_sync;
  end

  always @(negedge clk) begin
    #1;
    total++;
    if (data_ready !== exp_data_rdy() || svc_ready !== exp_svc_rdy()) begin
      bad++;
      $display("FAIL ready: data_ready=%b svc_ready=%b, want %b %b", data_ready, svc_ready, exp_data_rdy(), exp_svc_rdy());
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; gb_pause = 1'b0; data_valid = 1'b1; svc_valid = 1'b1;
    data_in = 64'hA5A5_0000_0000_0001; svc_in = 56'h12_3456_789A_BCDE;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (data_ready !== 1'b0 || svc_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: %b %b, want 0 0", data_ready, svc_ready); end
    total++; if (scr_enable !== 1'b0) begin bad++; $display("FAIL rst_en: %b, want 0", scr_enable); end
    total++; if (scr_data !== IDLE_WORD) begin bad++; $display("FAIL rst_data: %h, want %h", scr_data, IDLE_WORD); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done: %b, want 0", init_done); end
    data_valid = 1'b0; svc_valid = 1'b0;
  endtask

  task automatic test_init();
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < INITF; i++) begin
      @(posedge clk); #2;
      total++;
      if (scr_enable !== 1'b1 || frame_type !== ((i % 2 == 0) ? FT_CB : FT_IDLE) || init_done !== (i == INITF - 1)) begin
        bad++;
        $display("FAIL init_seq[%0d]: en=%b ft=%0d done=%b", i, scr_enable, frame_type, init_done);
      end
    end
    repeat (2) begin
      @(posedge clk); #2;
      total++;
      if (frame_type !== FT_IDLE || scr_sync !== SYNC_CTRL || init_done !== 1'b1) begin
        bad++;
        $display("FAIL post_init_idle: ft=%0d sync=%b done=%b, want 0 10 1", frame_type, scr_sync, init_done);
      end
    end
  endtask

  task automatic test_data_service();
    int gap, nsvc;
    @(negedge clk);
    data_valid = 1'b1; svc_valid = 1'b1; data_in = 64'hA5A5_0000_0000_0001;
    ft_log.delete();
    #1;
    total++; if (data_ready !== 1'b1 || svc_ready !== 1'b0) begin bad++; $display("FAIL data_wins: data_ready=%b svc_ready=%b, want 1 0", data_ready, svc_ready); end
    repeat (160) @(negedge clk);
    gap = -1; nsvc = 0;
    foreach (ft_log[k]) begin
      if (ft_log[k] == FT_SERVICE) begin
        if (gap >= 0) begin
          total++; if (gap != SP - 1) begin bad++; $display("FAIL svc_gap: %0d data frames, want %0d", gap, SP - 1); end
        end
        nsvc++; gap = 0;
      end else if (ft_log[k] == FT_DATA && gap >= 0) gap++;
    end
    total++; if (nsvc != 3) begin bad++; $display("FAIL svc_count: %0d, want 3", nsvc); end
    svc_valid = 1'b0;
  endtask

  task automatic test_pause();
    logic        hs;
    logic [47:0] seq;
    logic [63:0] held;
    hs = 1'b0; seq = 48'd100;
    @(negedge clk);
    svc_valid = 1'b0; data_valid = 1'b1; data_in = {16'hA5A5, seq};
    data_log.delete();
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (hs) begin seq = seq + 48'd1; data_in = {16'hA5A5, seq}; end
      gb_pause = (i % 3 == 2);
      #1;
      hs = data_ready; held = scr_data;
      if (gb_pause) begin
        total++; if (data_ready !== 1'b0 || svc_ready !== 1'b0) begin bad++; $display("FAIL pause_ready[%0d]: %b %b, want 0 0", i, data_ready, svc_ready); end
      end
      @(posedge clk); #2;
      if (gb_pause) begin
        total++; if (scr_enable !== 1'b0 || scr_data !== held) begin bad++; $display("FAIL pause_hold[%0d]: en=%b data=%h, want 0 %h", i, scr_enable, scr_data, held); end
      end
    end
    @(negedge clk); gb_pause = 1'b0;
    total++; if (data_log.size() != 40) begin bad++; $display("FAIL pause_count: %0d data frames, want 40", data_log.size()); end
    for (int k = 0; k < data_log.size(); k++) begin
      total++;
      if (data_log[k][47:0] !== 48'd100 + 48'(k)) begin
        bad++; $display("FAIL pause_seq[%0d]: id=%0d, want %0d", k, data_log[k][47:0], 100 + k);
      end
    end
  endtask

  task automatic test_svc_backlog();
    int guard, nsvc;
    @(negedge clk); gb_pause = 1'b0; svc_valid = 1'b0; data_valid = 1'b1;
    repeat (200) @(negedge clk);
    guard = 0;
    while (m_svc_cnt != 5 && guard < 100) begin @(negedge clk); guard++; end
    total++; if (guard >= 100 || !m_svc_due) begin bad++; $display("FAIL backlog_align: guard=%0d due=%b, want <100 1", guard, m_svc_due); end
    svc_valid = 1'b1; ft_log.delete();
    #1;
    total++; if (svc_ready !== 1'b1 || data_ready !== 1'b0) begin bad++; $display("FAIL backlog_grant: svc=%b data=%b, want 1 0", svc_ready, data_ready); end
    @(negedge clk); #1;
    total++; if (svc_ready !== 1'b0 || data_ready !== 1'b1) begin bad++; $display("FAIL backlog_no_burst: svc=%b data=%b, want 0 1", svc_ready, data_ready); end
    repeat (38) @(negedge clk);
    nsvc = 0;
    foreach (ft_log[k]) if (ft_log[k] == FT_SERVICE) nsvc++;
    total++; if (ft_log.size() == 0 || ft_log[0] != FT_SERVICE || nsvc != 1) begin bad++; $display("FAIL backlog_once: %0d services in %0d frames, want exactly 1 first", nsvc, ft_log.size()); end
    // Grant on the wrap slot itself: the re-armed flag gives a second service next slot.
    svc_valid = 1'b0;
    guard = 0;
    while (!(m_svc_due && m_svc_cnt == SP - 1) && guard < 200) begin @(negedge clk); guard++; end
    total++; if (guard >= 200) begin bad++; $display("FAIL wrap_align: guard=%0d, want <200", guard); end
    svc_valid = 1'b1; ft_log.delete();
    repeat (3) @(negedge clk);
    total++;
    if (ft_log.size() != 3 || ft_log[0] != FT_SERVICE || ft_log[1] != FT_SERVICE || ft_log[2] != FT_DATA) begin
      bad++; $display("FAIL wrap_grant: %0d frames ft0=%0d ft1=%0d, want S,S,D", ft_log.size(), ft_log[0], ft_log[1]);
    end
    svc_valid = 1'b0;
  endtask

  task automatic test_cb_periodic();
    int first;
    frame_type_e want;
    @(negedge clk); data_valid = 1'b1; svc_valid = 1'b1; ft_log.delete();
    repeat (40) @(negedge clk);
    first = -1;
    foreach (ft_log[k]) if (first < 0 && ft_log[k] == FT_CB) first = k;
    total++;
    if (first < 0 || first + 24 > ft_log.size()) begin
      bad++; $display("FAIL cb_found: first=%0d of %0d frames, want a CB with 24 frames after", first, ft_log.size());
    end else begin
      for (int j = 0; j < 24; j++) begin
        want = (j % 8 == 0) ? FT_CB : ((j % 8 == 1) ? FT_SERVICE : FT_DATA);
        total++;
        if (ft_log[first + j] != want) begin bad++; $display("FAIL cb_pattern[%0d]: ft=%0d, want %0d", j, ft_log[first + j], want); end
      end
    end
    data_valid = 1'b0; svc_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); data_valid = 1'b1; svc_valid = 1'b1; gb_pause = 1'b0; reset_n = 1'b0;
    #1;
    total++; if (data_ready !== 1'b0 || svc_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: %b %b, want 0 0", data_ready, svc_ready); end
    @(posedge clk); #2;
    total++;
    if (scr_enable !== 1'b0 || init_done !== 1'b0 || scr_data !== IDLE_WORD) begin
      bad++; $display("FAIL mid_rst_out: en=%b done=%b data=%h, want 0 0 %h", scr_enable, init_done, scr_data, IDLE_WORD);
    end
    @(negedge clk); reset_n = 1'b1; ft_log.delete();
    repeat (INITF - 1) @(posedge clk);
    @(negedge clk); gb_pause = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
      total++; if (scr_enable !== 1'b0 || init_done !== 1'b0) begin bad++; $display("FAIL init_pause: en=%b done=%b, want 0 0", scr_enable, init_done); end
    end
    @(negedge clk); gb_pause = 1'b0;
    @(posedge clk); #2;
    total++; if (init_done !== 1'b1 || frame_type !== FT_IDLE) begin bad++; $display("FAIL init_resume: done=%b ft=%0d, want 1 0", init_done, frame_type); end
    total++; if (ft_log.size() != INITF) begin bad++; $display("FAIL init_restart_len: %0d, want %0d", ft_log.size(), INITF); end
    for (int k = 0; k < ft_log.size(); k++) begin
      total++;
      if (ft_log[k] != ((k % 2 == 0) ? FT_CB : FT_IDLE)) begin bad++; $display("FAIL init_restart[%0d]: ft=%0d", k, ft_log[k]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
`ifdef TX_CB_PERIODIC_EN
    test_cb_periodic();
`else
    test_data_service();
    test_pause();
    test_svc_backlog();
`endif
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
